// File: rtl/sva_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : sva_result_collector
// Brief    : Counts checker success/fail/lazy pulses, keeps an aggregate
//            verdict and logs timestamps of fails in a small FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module sva_result_collector #(
    parameter int CNT_W = 16,
    parameter int TS_W  = 32,
    parameter int DEPTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             clr,
    input  logic             succ_i,
    input  logic             fail_i,
    input  logic             lazy_succ_i,
    output logic [CNT_W-1:0] succ_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] lazy_cnt,
    output logic [1:0]       verdict,
    output logic             err_sticky,
    output logic [TS_W-1:0]  first_fail_ts,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [TS_W-1:0]  evt_ts,
    output logic             ovf,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_PTR_ONE = (c_AW+1)'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [TS_W-1:0]  c_TS_ONE  = TS_W'(1);

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_PASS = 2'b01,
        ST_FAIL = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic [c_AW:0]   w_wr_nxt;
    logic [c_AW:0]   w_rd_nxt;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [TS_W-1:0] w_head_nxt;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v,
                                                   input logic en);
        return (en && (v != '1)) ? v + c_CNT_ONE : v;
    endfunction

    always_comb begin
        w_state_nxt = ST_NONE;
        case (r_state)
            ST_NONE: begin
                if (fail_i)
                    w_state_nxt = ST_FAIL;
                else if (succ_i || lazy_succ_i)
                    w_state_nxt = ST_PASS;
                else
                    w_state_nxt = ST_NONE;
            end
            ST_PASS: w_state_nxt = fail_i ? ST_FAIL : ST_PASS;
            ST_FAIL: w_state_nxt = ST_FAIL;
            default: w_state_nxt = ST_NONE;
        endcase
    end

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        w_empty  = (r_wr_ptr == r_rd_ptr);
        w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
        w_pop    = !w_empty && evt_ready;
        w_push   = fail_i && (!w_full || w_pop);
        w_drop   = fail_i && w_full && !w_pop;
        w_wr_nxt = w_push ? r_wr_ptr + c_PTR_ONE : r_wr_ptr;
        w_rd_nxt = w_pop  ? r_rd_ptr + c_PTR_ONE : r_rd_ptr;
        // Forward the incoming timestamp when it becomes the new head.
        if (w_push && (r_wr_ptr[c_AW-1:0] == w_rd_nxt[c_AW-1:0]))
            w_head_nxt = r_ts;
        else
            w_head_nxt = r_mem[w_rd_nxt[c_AW-1:0]];
    end

    always_ff @(posedge sys_clk) begin
        if (w_push && !clr)
            r_mem[r_wr_ptr[c_AW-1:0]] <= r_ts;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ts          <= '0;
            r_state       <= ST_NONE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            succ_cnt      <= '0;
            fail_cnt      <= '0;
            lazy_cnt      <= '0;
            drop_cnt      <= '0;
            verdict       <= ST_NONE;
            err_sticky    <= 1'b0;
            first_fail_ts <= '0;
            evt_valid     <= 1'b0;
            evt_ts        <= '0;
            ovf           <= 1'b0;
        end else if (clr) begin
            r_ts          <= '0;
            r_state       <= ST_NONE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            succ_cnt      <= '0;
            fail_cnt      <= '0;
            lazy_cnt      <= '0;
            drop_cnt      <= '0;
            verdict       <= ST_NONE;
            err_sticky    <= 1'b0;
            first_fail_ts <= '0;
            evt_valid     <= 1'b0;
            evt_ts        <= '0;
            ovf           <= 1'b0;
        end else begin
            r_ts          <= r_ts + c_TS_ONE;
            r_state       <= w_state_nxt;
            r_wr_ptr      <= w_wr_nxt;
            r_rd_ptr      <= w_rd_nxt;
            succ_cnt      <= f_sat_inc(succ_cnt, succ_i);
            fail_cnt      <= f_sat_inc(fail_cnt, fail_i);
            lazy_cnt      <= f_sat_inc(lazy_cnt, lazy_succ_i);
            drop_cnt      <= f_sat_inc(drop_cnt, w_drop);
            verdict       <= w_state_nxt;
            err_sticky    <= err_sticky | fail_i;
            if (fail_i && !err_sticky)
                first_fail_ts <= r_ts;
            evt_valid     <= (w_wr_nxt != w_rd_nxt);
            evt_ts        <= w_head_nxt;
            ovf           <= ovf | w_drop;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sva_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_sva_result_collector
// Brief    : Directed table, corner sequences and random run against a
//            queue-based reference model of the result collector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sva_result_collector;

    localparam int CNT_W  = 4;
    localparam int TS_W   = 8;
    localparam int DEPTH  = 8;
    localparam int MAXC   = (1 << CNT_W) - 1;
    localparam int TS_MOD = 1 << TS_W;

    logic             sys_clk;
    logic             sys_rst;
    logic             clr;
    logic             succ_i;
    logic             fail_i;
    logic             lazy_succ_i;
    logic             evt_ready;
    logic [CNT_W-1:0] succ_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] lazy_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic [1:0]       verdict;
    logic             err_sticky;
    logic [TS_W-1:0]  first_fail_ts;
    logic             evt_valid;
    logic [TS_W-1:0]  evt_ts;
    logic             ovf;

    sva_result_collector #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .clr           (clr),
        .succ_i        (succ_i),
        .fail_i        (fail_i),
        .lazy_succ_i   (lazy_succ_i),
        .succ_cnt      (succ_cnt),
        .fail_cnt      (fail_cnt),
        .lazy_cnt      (lazy_cnt),
        .verdict       (verdict),
        .err_sticky    (err_sticky),
        .first_fail_ts (first_fail_ts),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_ts        (evt_ts),
        .ovf           (ovf),
        .drop_cnt      (drop_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: plain integers plus a queue of logged timestamps.
    int m_ts, m_succ, m_fail, m_lazy, m_drop, m_verdict, m_first;
    bit m_err, m_ovf;
    int m_q[$];

    typedef struct {
        logic succ, fail, lazy, ready;
        int   e_succ, e_fail, e_lazy, e_verdict, e_err, e_valid, e_head, e_first;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic model_reset();
        m_ts = 0; m_succ = 0; m_fail = 0; m_lazy = 0; m_drop = 0;
        m_verdict = 0; m_first = 0; m_err = 0; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit pop, drop;
        if (clr) begin
            model_reset();
            return;
        end
        pop  = (m_q.size() > 0) && evt_ready;
        drop = fail_i && (m_q.size() == DEPTH) && !pop;
        if (pop) void'(m_q.pop_front());
        if (fail_i && !drop) m_q.push_back(m_ts);
        if (drop) begin
            m_drop = sat(m_drop);
            m_ovf  = 1;
        end
        if (succ_i)      m_succ = sat(m_succ);
        if (fail_i)      m_fail = sat(m_fail);
        if (lazy_succ_i) m_lazy = sat(m_lazy);
        if (fail_i)
            m_verdict = 2;
        else if (m_verdict == 0 && (succ_i || lazy_succ_i))
            m_verdict = 1;
        if (fail_i && !m_err) m_first = m_ts;
        if (fail_i) m_err = 1;
        m_ts = (m_ts + 1) % TS_MOD;
    endtask

    task automatic chk_model();
        chk("succ_cnt", succ_cnt, m_succ);
        chk("fail_cnt", fail_cnt, m_fail);
        chk("lazy_cnt", lazy_cnt, m_lazy);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("verdict", verdict, m_verdict);
        chk("err_sticky", err_sticky, m_err);
        chk("ovf", ovf, m_ovf);
        chk("first_fail_ts", first_fail_ts, m_first);
        chk("evt_valid", evt_valid, m_q.size() > 0);
        if (m_q.size() > 0) chk("evt_ts", evt_ts, m_q[0]);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".succ_cnt"}, succ_cnt, 0);
        chk({tag, ".fail_cnt"}, fail_cnt, 0);
        chk({tag, ".lazy_cnt"}, lazy_cnt, 0);
        chk({tag, ".drop_cnt"}, drop_cnt, 0);
        chk({tag, ".verdict"}, verdict, 0);
        chk({tag, ".err_sticky"}, err_sticky, 0);
        chk({tag, ".ovf"}, ovf, 0);
        chk({tag, ".first_fail_ts"}, first_fail_ts, 0);
        chk({tag, ".evt_valid"}, evt_valid, 0);
    endtask

    task automatic idle_inputs();
        clr = 0; succ_i = 0; fail_i = 0; lazy_succ_i = 0; evt_ready = 0;
    endtask

    task automatic step();
        @(posedge sys_clk);
        model_step();
        #1;
        chk_model();
    endtask

    // Reset is raised mid-cycle so the asynchronous clear is observed before any edge.
    task automatic do_reset();
        idle_inputs();
        #2;
        sys_rst = 1;
        #1;
        chk_zero("rst");
        model_reset();
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        sys_rst = 0;
    endtask

    int exp_drain[8];
    int rdy_pct;

    initial begin
        sys_rst = 0;
        idle_inputs();
        model_reset();
        //          s  f  l  r   succ fail lazy verd err val head first
        tbl[0]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0};
        tbl[1]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0};
        tbl[2]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0};
        tbl[3]  = '{1, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0,  0};
        tbl[4]  = '{0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0,  0};
        tbl[5]  = '{1, 0, 0, 0,  2, 0, 0, 1, 0, 0, 0,  0};
        tbl[6]  = '{0, 0, 1, 0,  2, 0, 1, 1, 0, 0, 0,  0};
        tbl[7]  = '{1, 0, 1, 0,  3, 0, 2, 1, 0, 0, 0,  0};
        tbl[8]  = '{0, 0, 0, 1,  3, 0, 2, 1, 0, 0, 0,  0};
        tbl[9]  = '{0, 0, 0, 0,  3, 0, 2, 1, 0, 0, 0,  0};
        tbl[10] = '{0, 1, 0, 0,  3, 1, 2, 2, 1, 1, 10, 10};
        tbl[11] = '{0, 0, 0, 0,  3, 1, 2, 2, 1, 1, 10, 10};
        tbl[12] = '{1, 0, 0, 0,  4, 1, 2, 2, 1, 1, 10, 10};
        tbl[13] = '{0, 0, 0, 0,  4, 1, 2, 2, 1, 1, 10, 10};
        tbl[14] = '{0, 1, 0, 0,  4, 2, 2, 2, 1, 1, 10, 10};
        tbl[15] = '{0, 0, 0, 1,  4, 2, 2, 2, 1, 1, 14, 10};
        tbl[16] = '{0, 0, 0, 1,  4, 2, 2, 2, 1, 0, 0,  10};
        tbl[17] = '{0, 0, 0, 1,  4, 2, 2, 2, 1, 0, 0,  10};
        #1;

        // Table: row i is sampled in the cycle where ts == i.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            succ_i = tbl[i].succ; fail_i = tbl[i].fail;
            lazy_succ_i = tbl[i].lazy; evt_ready = tbl[i].ready;
            step();
            chk($sformatf("tbl%0d.succ_cnt", i), succ_cnt, tbl[i].e_succ);
            chk($sformatf("tbl%0d.fail_cnt", i), fail_cnt, tbl[i].e_fail);
            chk($sformatf("tbl%0d.lazy_cnt", i), lazy_cnt, tbl[i].e_lazy);
            chk($sformatf("tbl%0d.verdict", i), verdict, tbl[i].e_verdict);
            chk($sformatf("tbl%0d.err_sticky", i), err_sticky, tbl[i].e_err);
            chk($sformatf("tbl%0d.evt_valid", i), evt_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d.first_fail_ts", i), first_fail_ts, tbl[i].e_first);
            if (tbl[i].e_valid != 0)
                chk($sformatf("tbl%0d.evt_ts", i), evt_ts, tbl[i].e_head);
        end
        idle_inputs();

        // Success and fail in the same cycle.
        do_reset();
        succ_i = 1; fail_i = 1;
        step();
        idle_inputs();
        chk("same.succ_cnt", succ_cnt, 1);
        chk("same.fail_cnt", fail_cnt, 1);
        chk("same.verdict", verdict, 2);

        // Overfill, then push+pop while full, then drain.
        do_reset();
        fail_i = 1;
        repeat (10) step();
        fail_i = 0;
        chk("fill.fail_cnt", fail_cnt, 10);
        chk("fill.drop_cnt", drop_cnt, 2);
        chk("fill.ovf", ovf, 1);
        chk("fill.evt_valid", evt_valid, 1);
        chk("fill.evt_ts", evt_ts, 0);
        fail_i = 1; evt_ready = 1;
        step();
        fail_i = 0; evt_ready = 0;
        chk("fullpp.drop_cnt", drop_cnt, 2);
        chk("fullpp.fail_cnt", fail_cnt, 11);
        chk("fullpp.evt_ts", evt_ts, 1);
        exp_drain = '{1, 2, 3, 4, 5, 6, 7, 10};
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d.evt_valid", k), evt_valid, 1);
            chk($sformatf("drain%0d.evt_ts", k), evt_ts, exp_drain[k]);
            evt_ready = 1;
            step();
        end
        evt_ready = 0;
        chk("drain.empty", evt_valid, 0);
        chk("drain.ovf_held", ovf, 1);

        // Counter saturation, then clr colliding with a fail.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            succ_i = 1;
            step();
            succ_i = 0;
            step();
        end
        chk("sat.succ_cnt", succ_cnt, MAXC);
        clr = 1; fail_i = 1;
        step();
        idle_inputs();
        chk_zero("clr");

        // Random traffic with bursty consumer.
        do_reset();
        rdy_pct = 50;
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) rdy_pct = (i / 200 % 3 == 0) ? 10 : ((i / 200 % 3 == 1) ? 90 : 50);
            if (i == 700) do_reset();
            succ_i      = ($urandom_range(0, 2) == 0);
            fail_i      = ($urandom_range(0, 4) == 0);
            lazy_succ_i = ($urandom_range(0, 3) == 0);
            evt_ready   = ($urandom_range(0, 99) < rdy_pct);
            clr         = ($urandom_range(0, 399) == 0);
            step();
        end
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
